cdc_cmd_parser: RTL and testbench

CDC_CMD_PARSER -- requirements
Module: cdc_cmd_parser

---
 rtl/cdc_pkg.sv | 16 +
 rtl/cdc_byte_timer.sv | 40 ++++
 rtl/cdc_cmd_parser.sv | 178 +++++++++++++++++
 tb/tb_cdc_cmd_parser.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared constants and state encoding for the command-frame parser.
// Frame layout: SOF, CMD, LEN, LEN payload bytes, CHK.
package cdc_pkg;

    localparam int         BYTE_W = 8;
    localparam logic [7:0] SOF    = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } state_e;

endpackage

// File: rtl/cdc_byte_timer.sv
// Inter-byte watchdog for the frame parser.
// Compiled only when CDC_PARSER_TIMEOUT_EN is defined.
`ifdef CDC_PARSER_TIMEOUT_EN
module cdc_byte_timer #(
    parameter int unsigned CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires on the cycle whose closing edge would be the CYCLES-th without a pop.
    assign expire = enable && !clear && (cnt_q == CW'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/cdc_cmd_parser.sv
// Byte-stream frame parser fed by a fall-through FIFO.
// Optional inter-byte timeout enabled by defining CDC_PARSER_TIMEOUT_EN.
module cdc_cmd_parser
    import cdc_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] fifo_rdata,
    input  logic              fifo_rempty,
    output logic              fifo_rinc,
    output logic              hdr_valid,
    output logic [BYTE_W-1:0] hdr_cmd,
    output logic [BYTE_W-1:0] hdr_len,
    output logic              pl_valid,
    output logic [BYTE_W-1:0] pl_data,
    input  logic              pl_ready,
    output logic              frm_done,
    output logic              frm_ok,
    output logic [BYTE_W-1:0] err_cnt
);

    localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

    state_e            state_q, state_d;
    logic              run_q;
    logic [BYTE_W-1:0] cmd_q, cmd_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic [BYTE_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0] hdr_cmd_q, hdr_cmd_d;
    logic [BYTE_W-1:0] hdr_len_q, hdr_len_d;
    logic              hdr_valid_q, hdr_valid_d;
    logic              frm_done_q, frm_done_d;
    logic              frm_ok_q, frm_ok_d;
    logic [BYTE_W-1:0] err_cnt_q, err_cnt_d;
    logic              err_inc;
    logic              pop;
    logic              tmo_expire;

`ifdef CDC_PARSER_TIMEOUT_EN
    cdc_byte_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (pop),
        .enable (run_q && (state_q != ST_IDLE)),
        .expire (tmo_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_expire         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        hdr_cmd_d   = hdr_cmd_q;
        hdr_len_d   = hdr_len_q;
        hdr_valid_d = 1'b0;
        frm_done_d  = 1'b0;
        frm_ok_d    = 1'b0;
        err_inc     = 1'b0;
        pop         = 1'b0;
        pl_valid    = 1'b0;
        pl_data     = '0;

        // run_q keeps the FIFO untouched while reset is (or was just) asserted.
        if (run_q) begin
            case (state_q)
                ST_IDLE: begin
                    pop = !fifo_rempty;
                    if (pop && (fifo_rdata == SOF)) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    pop = !fifo_rempty;
                    if (pop) begin
                        cmd_d   = fifo_rdata;
                        chk_d   = fifo_rdata;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    pop = !fifo_rempty;
                    if (pop) begin
                        if (fifo_rdata > MAX_LEN_B) begin
                            state_d    = ST_IDLE;
                            frm_done_d = 1'b1;
                            err_inc    = 1'b1;
                        end else begin
                            hdr_cmd_d   = cmd_q;
                            hdr_len_d   = fifo_rdata;
                            hdr_valid_d = 1'b1;
                            chk_d       = chk_q ^ fifo_rdata;
                            cnt_d       = fifo_rdata;
                            state_d     = (fifo_rdata == '0) ? ST_CHK : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    pl_valid = !fifo_rempty;
                    pl_data  = pl_valid ? fifo_rdata : '0;
                    pop      = pl_valid && pl_ready;
                    if (pop) begin
                        chk_d = chk_q ^ fifo_rdata;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == 8'd1) begin
                            state_d = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    pop = !fifo_rempty;
                    if (pop) begin
                        frm_done_d = 1'b1;
                        frm_ok_d   = (fifo_rdata == chk_q);
                        err_inc    = (fifo_rdata != chk_q);
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (tmo_expire) begin
                state_d    = ST_IDLE;
                frm_done_d = 1'b1;
                frm_ok_d   = 1'b0;
                err_inc    = 1'b1;
            end
        end

        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            cmd_q       <= '0;
            chk_q       <= '0;
            cnt_q       <= '0;
            hdr_cmd_q   <= '0;
            hdr_len_q   <= '0;
            hdr_valid_q <= 1'b0;
            frm_done_q  <= 1'b0;
            frm_ok_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            cmd_q       <= cmd_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            hdr_cmd_q   <= hdr_cmd_d;
            hdr_len_q   <= hdr_len_d;
            hdr_valid_q <= hdr_valid_d;
            frm_done_q  <= frm_done_d;
            frm_ok_q    <= frm_ok_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign fifo_rinc = pop;
    assign hdr_valid = hdr_valid_q;
    assign hdr_cmd   = hdr_cmd_q;
    assign hdr_len   = hdr_len_q;
    assign frm_done  = frm_done_q;
    assign frm_ok    = frm_ok_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cdc_cmd_parser.sv
// Scoreboard bench for cdc_cmd_parser: stimulus queues bytes and expected events,
// a monitor pops and compares whenever the DUT presents header, payload or frame-end.
module tb_cdc_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rempty = 1'b1;
    logic       fifo_rinc;
    logic       hdr_valid;
    logic [7:0] hdr_cmd;
    logic [7:0] hdr_len;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready = 1'b1;
    logic       frm_done;
    logic       frm_ok;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    cdc_cmd_parser #(
        .MAX_LEN        (64),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .hdr_valid   (hdr_valid),
        .hdr_cmd     (hdr_cmd),
        .hdr_len     (hdr_len),
        .pl_valid    (pl_valid),
        .pl_data     (pl_data),
        .pl_ready    (pl_ready),
        .frm_done    (frm_done),
        .frm_ok      (frm_ok),
        .err_cnt     (err_cnt)
    );

    // kind: 0 header(a=cmd,b=len), 1 payload(a=data), 2 frame end(a=ok,b=err_cnt),
    // 3 frame end by timeout (also checks distance from the last pop)
    typedef struct {
        int kind;
        int a;
        int b;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         vecs = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_pop = 0;
    int         exp_err = 0;
    bit         toggle_en = 1'b0;
    bit         rinc_pend = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc++;

    // Fall-through FIFO model; inputs change only on the falling edge.
    always @(negedge clk) begin
        if (rinc_pend && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            last_pop = cyc;
        end
        pl_ready    = toggle_en ? !pl_ready : 1'b1;
        fifo_rempty = (fifo_q.size() == 0);
        fifo_rdata  = fifo_rempty ? 8'h00 : fifo_q[0];
        #1;
        rinc_pend = fifo_rinc;
    end

    task automatic take(input int kind, input int a, input int b);
        exp_t e;
        vecs++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: kind=%0d a=%02h b=%02h, required no event", kind, a, b);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind == 3) begin
            if (kind != 2 || a != 0 || b != e.b || (cyc - last_pop) != 16) begin
                fails++;
                $display("FAIL timeout_end: kind=%0d ok=%0d err=%0d gap=%0d, required kind=2 ok=0 err=%0d gap=16",
                         kind, a, b, cyc - last_pop, e.b);
            end else begin
                $display("timeout frame end ok=0 err=%0d gap=16", b);
            end
        end else if (e.kind != kind || e.a != a || e.b != b) begin
            fails++;
            $display("FAIL event_%0d: kind=%0d a=%02h b=%02h, required kind=%0d a=%02h b=%02h",
                     vecs, kind, a, b, e.kind, e.a, e.b);
        end else begin
            $display("event kind=%0d a=%02h b=%02h", kind, a, b);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (fifo_rinc) begin
                vecs++;
                if (fifo_rempty) begin
                    fails++;
                    $display("FAIL pop_while_empty: fifo_rinc=1 with fifo_rempty=1, required no pop");
                end
            end
            if (prev_stall && pl_valid) begin
                vecs++;
                if (pl_data != prev_data) begin
                    fails++;
                    $display("FAIL pl_stable: pl_data=%02h, required %02h", pl_data, prev_data);
                end
            end
            if (hdr_valid)            take(0, int'(hdr_cmd), int'(hdr_len));
            if (pl_valid && pl_ready) take(1, int'(pl_data), 0);
            if (frm_done)             take(2, int'(frm_ok), int'(err_cnt));
        end
        prev_stall = rst_n && pl_valid && !pl_ready;
        prev_data  = pl_data;
    end

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic e_hdr(input int c, input int l);
        exp_q.push_back('{0, c, l});
    endtask

    task automatic e_pl(input int d);
        exp_q.push_back('{1, d, 0});
    endtask

    task automatic e_done(input bit ok);
        if (!ok && exp_err < 255) exp_err++;
        exp_q.push_back('{2, int'(ok), exp_err});
    endtask

    task automatic e_tmo();
        if (exp_err < 255) exp_err++;
        exp_q.push_back('{3, 0, exp_err});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        vecs++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d events outstanding after %0d cycles, required 0", name, exp_q.size(), n);
            exp_q.delete();
            fifo_q.delete();
        end else begin
            $display("%s complete", name);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [44:0] act;
        act = {fifo_rinc, hdr_valid, hdr_cmd, hdr_len, pl_valid, pl_data, frm_done, frm_ok, err_cnt};
        vecs++;
        if (act != '0) begin
            fails++;
            $display("FAIL %s: outputs=%h, required all zero", name, act);
        end else begin
            $display("%s outputs zero", name);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #3;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three back-to-back frames; 0x30 = 01^02^11^22, 0x07 = 07^00.
        push(8'hA5); push(8'h01); push(8'h02); push(8'h11); push(8'h22); push(8'h30);
        push(8'hA5); push(8'h07); push(8'h00); push(8'h07);
        push(8'hA5); push(8'h07); push(8'h00); push(8'h08);
        e_hdr(8'h01, 8'h02); e_pl(8'h11); e_pl(8'h22); e_done(1'b1);
        e_hdr(8'h07, 8'h00); e_done(1'b1);
        e_hdr(8'h07, 8'h00); e_done(1'b0);
        drain("basic_and_len0");

        // Leading garbage dropped, then 0x46 = 03^01^44.
        push(8'h00); push(8'hFF); push(8'h5A);
        push(8'hA5); push(8'h03); push(8'h01); push(8'h44); push(8'h46);
        e_hdr(8'h03, 8'h01); e_pl(8'h44); e_done(1'b1);
        drain("garbage");

        // LEN 0x41 over MAX_LEN, then a good frame: 0x30 = 02^01^33.
        push(8'hA5); push(8'h10); push(8'h41);
        push(8'hA5); push(8'h02); push(8'h01); push(8'h33); push(8'h30);
        e_done(1'b0);
        e_hdr(8'h02, 8'h01); e_pl(8'h33); e_done(1'b1);
        drain("len_too_big");

        // LEN == MAX_LEN with payload 0..63 (XOR 0): chk = 20^40 = 60.
        push(8'hA5); push(8'h20); push(8'h40);
        e_hdr(8'h20, 8'h40);
        for (int i = 0; i < 64; i++) begin
            push(8'(i));
            e_pl(i);
        end
        push(8'h60);
        e_done(1'b1);
        drain("len_max");

        // Toggling ready and an empty FIFO mid-payload; chk = 09^08^(01..08)=09^08^08 = 09.
        toggle_en = 1'b1;
        push(8'hA5); push(8'h09); push(8'h08);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        e_hdr(8'h09, 8'h08);
        for (int i = 1; i <= 8; i++) e_pl(i);
        e_done(1'b1);
        repeat (25) @(negedge clk);
        push(8'h05); push(8'h06); push(8'h07); push(8'h08); push(8'h09);
        drain("ready_toggle");
        toggle_en = 1'b0;

        // Reset mid-payload: partial frame discarded without a frame end.
        push(8'hA5); push(8'h05); push(8'h05); push(8'hAA); push(8'hBB);
        e_hdr(8'h05, 8'h05); e_pl(8'hAA); e_pl(8'hBB);
        drain("partial_frame");
        rst_n = 1'b0;
        exp_err = 0;
        push(8'hA5); push(8'h07); push(8'h00); push(8'h07);
        repeat (2) @(negedge clk);
        #3;
        check_reset_outputs("reset_mid_payload");
        @(negedge clk);
        rst_n = 1'b1;
        e_hdr(8'h07, 8'h00); e_done(1'b1);
        drain("after_reset");

`ifdef CDC_PARSER_TIMEOUT_EN
        push(8'hA5); push(8'h10);
        e_tmo();
        drain("timeout");
`endif

        // Oversize frames until err_cnt saturates.
        for (int i = 0; i < 260; i++) begin
            push(8'hA5); push(8'h00); push(8'hFF);
            e_done(1'b0);
        end
        drain("err_saturate");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
